// File: rtl/key_flag_indicator_if.sv
// key_flag_indicator_if: event/indicator signal bundle between event producer and blink indicator
//   flag_in  event strobe (producer -> indicator)
//   clr_in   overflow clear (producer -> indicator)
//   ind_out  indicator drive, busy, pending[3:0], overflow (indicator -> observer)
interface key_flag_indicator_if;
  logic       flag_in;
  logic       clr_in;
  logic       ind_out;
  logic       busy;
  logic [3:0] pending;
  logic       overflow;
  modport master (output flag_in, clr_in, input ind_out, busy, pending, overflow);
  modport slave  (input flag_in, clr_in, output ind_out, busy, pending, overflow);
endinterface

// File: rtl/key_flag_indicator.sv
// key_flag_indicator: turns event pulses into timed ON/OFF blinks, queueing events that arrive mid-blink
//   system_clk    clock
//   system_reset  asynchronous active-high reset
//   bus.slave     flag_in, clr_in in; ind_out, busy, pending, overflow out (all registered)
module key_flag_indicator #(
  parameter logic [23:0] ON_CNT_MAX   = 24'd12_499_999,
  parameter logic [23:0] OFF_CNT_MAX  = 24'd12_499_999,
  parameter logic [3:0]  PEND_MAX     = 4'd15,
  parameter logic        ACTIVE_LEVEL = 1'b1
) (
  input logic                 system_clk,
  input logic                 system_reset,
  key_flag_indicator_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [3:0]  pend_q, pend_d;
  logic        ovf_q, ovf_d, ind_q, ind_d, busy_q, busy_d;
  logic        on_end, off_end, inc, dec, ovf_set;
  always_comb begin
    on_end  = state_q == ON && cnt_q == ON_CNT_MAX;
    off_end = state_q == OFF && cnt_q == OFF_CNT_MAX;
    dec     = off_end && pend_q != 4'd0;
    // a flag on the consuming OFF-end cycle with nothing queued starts the next blink directly
    inc     = bus.flag_in && state_q != IDLE && !(off_end && pend_q == 4'd0);
    ovf_set = inc && !dec && pend_q == PEND_MAX;
    pend_d  = (inc && !dec && pend_q != PEND_MAX) ? pend_q + 4'd1 :
              (!inc && dec)                       ? pend_q - 4'd1 : pend_q;
    ovf_d   = ovf_set ? 1'b1 : bus.clr_in ? 1'b0 : ovf_q;
    state_d = state_q == IDLE ? (bus.flag_in ? ON : IDLE) :
              state_q == ON   ? (on_end ? OFF : ON) :
              off_end         ? ((dec || bus.flag_in) ? ON : IDLE) : OFF;
    cnt_d   = (state_d != state_q || state_q == IDLE) ? 24'd0 : cnt_q + 24'd1;
    ind_d   = state_d == ON ? ACTIVE_LEVEL : ~ACTIVE_LEVEL;
    busy_d  = state_d != IDLE;
  end
  always_ff @(posedge system_clk or posedge system_reset) begin
    if (system_reset) begin
      state_q <= IDLE;
      cnt_q   <= 24'd0;
      pend_q  <= 4'd0;
      ovf_q   <= 1'b0;
      ind_q   <= ~ACTIVE_LEVEL;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      ind_q   <= ind_d;
      busy_q  <= busy_d;
    end
  end
  assign bus.ind_out  = ind_q;
  assign bus.busy     = busy_q;
  assign bus.pending  = pend_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_key_flag_indicator.sv
// tb_key_flag_indicator: directed and randomized checks of key_flag_indicator against a blink-budget model
module tb_key_flag_indicator;
  localparam int ON = 3, OFF = 1, PM = 3;
  localparam int PERIOD = ON + 1 + OFF + 1;
  logic system_clk = 0, system_reset = 0;
  int n_chk = 0, n_err = 0;
  int m_left = 0, m_pend = 0, m_ovf = 0;
  key_flag_indicator_if bus ();
  key_flag_indicator #(.ON_CNT_MAX(24'(ON)), .OFF_CNT_MAX(24'(OFF)), .PEND_MAX(4'(PM)), .ACTIVE_LEVEL(1'b1))
    dut (.system_clk(system_clk), .system_reset(system_reset), .bus(bus.slave));
  always #5 system_clk = ~system_clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic compare();
    chk("ind", int'(bus.ind_out), int'(m_left > OFF + 1));
    chk("busy", int'(bus.busy), int'(m_left > 0));
    chk("pending", int'(bus.pending), m_pend);
    chk("overflow", int'(bus.overflow), m_ovf);
  endtask
  task automatic model(input bit f, input bit c);
    bit set = 0;
    if (m_left == 0) begin
      if (f) m_left = PERIOD;
    end else if (m_left == 1) begin
      if (m_pend > 0) begin
        m_pend = m_pend - 1 + int'(f);
        m_left = PERIOD;
      end else m_left = f ? PERIOD : 0;
    end else begin
      m_left--;
      if (f) begin
        if (m_pend == PM) set = 1;
        else m_pend++;
      end
    end
    m_ovf = set ? 1 : c ? 0 : m_ovf;
  endtask
  task automatic step(input bit f, input bit c);
    bus.flag_in = f;
    bus.clr_in = c;
    @(posedge system_clk);
    model(f, c);
    #1 compare();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0);
  endtask
  task automatic async_reset();
    system_reset = 1;
    #1;
    m_left = 0; m_pend = 0; m_ovf = 0;
    compare();
    @(posedge system_clk);
    #1 compare();
    system_reset = 0;
  endtask
  initial begin
    bus.flag_in = 0;
    bus.clr_in = 0;
    #1 system_reset = 1;
    #2 compare();
    @(posedge system_clk);
    #1 system_reset = 0;
    idle(20);
    step(1, 0);
    idle(8);
    step(1, 0); step(1, 0); step(1, 0); step(1, 0);
    idle(30);
    step(1, 0);
    for (int i = 0; i < 6; i++) step(1, 0);
    step(0, 1);
    step(1, 0);
    step(1, 1);
    chk("ovf_set_wins", int'(bus.overflow), 1);
    idle(30);
    step(1, 0);
    idle(PERIOD - 1);
    step(1, 0);
    chk("direct_reblink", int'(bus.ind_out), 1);
    chk("direct_pend", int'(bus.pending), 0);
    idle(10);
    step(1, 0); step(1, 0); step(1, 0);
    async_reset();
    chk("rst_ind", int'(bus.ind_out), 0);
    step(1, 0);
    idle(8);
    for (int blk = 0; blk < 8; blk++) begin
      automatic int dens = (blk * 37 + 5) % 90;
      for (int i = 0; i < 200; i++)
        step($urandom_range(0, 99) < dens, $urandom_range(0, 15) == 0);
      if (blk == 4) async_reset();
    end
    idle(40);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/key_flag_indicator.md
Name: key_flag_indicator

Overview:
- Turns single-cycle event pulses (e.g. a debounced key flag or a read-done strobe) into a visible, timed indicator output for an LED or scope probe.
- Each input event produces one ON/OFF blink of parameterised length.
- Events arriving while a blink is in progress are queued in a saturating pending counter and replayed back to back.
- Sits between event producers and board LED pins in the SPI flash read design.

Parameters:
- ON_CNT_MAX, 24'd12_499_999: indicator ON duration minus 1, in clocks (250 ms at 50 MHz).
- OFF_CNT_MAX, 24'd12_499_999: OFF gap after each blink minus 1, in clocks.
- PEND_MAX, 4'd15: saturation value of the pending-event counter; legal range 1..15.
- ACTIVE_LEVEL, 1'b1: ind_out level while ON; the inactive level is its inverse.

Ports:
- system_clk  input  1  system clock (50 MHz).
- system_reset  input  1  asynchronous, active-high reset.
- flag_in  input  1  event strobe; every cycle sampled high is one event.
- clr_in  input  1  clears the overflow flag.
- ind_out  output  1  indicator drive.
- busy  output  1  high when state is not IDLE.
- pending  output  4  queued events not yet started.
- overflow  output  1  sticky; set when an event is dropped at saturation.

Interface (already decided): one clock; reset is asynchronous and active-high; clock port system_clk, reset port system_reset.

Behaviour:
- Reset (async, immediate, including mid-blink):
  - state IDLE, cnt 0.
  - ind_out = ~ACTIVE_LEVEL.
  - busy 0, pending 0, overflow 0.
- All outputs are registered.
- States: IDLE, ON, OFF. 24-bit cnt; cnt clears on every state change.
- IDLE:
  - flag_in=1 -> ON on the next edge; ind_out = ACTIVE_LEVEL, busy 1.
  - The event is consumed directly, so pending is unchanged.
  - Latency from flag_in sampled to ind_out active: 1 cycle.
- ON:
  - cnt increments each cycle.
  - At cnt==ON_CNT_MAX -> OFF, ind_out inactive.
  - ON lasts exactly ON_CNT_MAX+1 cycles.
- OFF:
  - cnt increments each cycle.
  - At cnt==OFF_CNT_MAX: if pending>0 or flag_in=1 -> ON (one event consumed); else -> IDLE, busy 0 on the same edge.
  - OFF lasts exactly OFF_CNT_MAX+1 cycles.
  - The OFF gap is always inserted, including after the last blink.
- Pending update, every cycle: pending_next = pending + inc - dec.
  - inc = flag_in and state≠IDLE.
  - dec = consume at OFF end and pending>0.
  - A flag_in arriving on the consuming OFF-end cycle with pending==0 is consumed directly: inc=dec=0 and pending stays 0.
- Saturation:
  - If inc=1, dec=0 and pending==PEND_MAX: pending holds and overflow sets.
  - If inc=1, dec=1 at PEND_MAX: pending holds and overflow is not set.
- overflow:
  - Cleared by clr_in=1.
  - If a set event and clr_in occur in the same cycle, set wins.
- flag_in held high for N cycles counts as N events; no edge detection is done here.
- No wrap-around anywhere: pending saturates, and cnt never exceeds its current *_CNT_MAX.

Test Plan (ON_CNT_MAX=3, OFF_CNT_MAX=1, PEND_MAX=3 unless noted):
- Reset release with flag_in=0 for 20 cycles -> ind_out=0, busy=0, pending=0, overflow=0 throughout.
- Single flag_in pulse at edge 0 -> ind_out=1 for edges 1..4, 0 for edges 5..6, busy falls at edge 7, pending stays 0.
- Three pulses during the first ON -> pending steps 1,2,3, then decrements at each OFF end; four blinks separated by exactly 2-cycle gaps; busy returns 0 after the final OFF.
- Six pulses while busy (PEND_MAX=3) -> pending saturates at 3, overflow=1 from the 4th queued pulse; clr_in pulse clears overflow; clr_in coincident with another dropped pulse leaves overflow=1.
- flag_in on the exact OFF-end cycle with pending=0 -> next edge enters ON, pending stays 0, no IDLE cycle.
- system_reset asserted 2 cycles into ON with pending=2 -> ind_out inactive, pending=0, busy=0 immediately (asynchronous); after release, the next pulse behaves as the single-pulse case.
